ysyx_24100006_clint_mh: RTL and testbench

- Next-generation core-local interruptor: a 64-bit mtime counter with a configurable tick prescaler.
- Per-hart mtimecmp and msip registers, each hart with its own timer and software interrupt outputs.
- Full AXI-Lite slave with read and write channels, SLVERR for unmapped addresses, and an atomic 64-bit mtime read via a hi-word snapshot.
- Sits on the MEM-stage peripheral crossbar beside the UART and SRAM slaves.

---
 rtl/ysyx_24100006_clint_pkg.sv | 83 ++++++++
 rtl/ysyx_24100006_clint_hart_ctx.sv | 39 +++
 rtl/ysyx_24100006_clint_mh.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_24100006_clint_mh.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_clint_pkg.sv
// Shared definitions for the multi-hart CLINT: register offsets, AXI response
// codes, channel FSM encodings, address decode and byte-lane merge helpers.
package ysyx_24100006_clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_LO_OFF = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF = 16'hBFFC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_HART = 8;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_MSIP  = 2'd1,
    SEL_CMP   = 2'd2,
    SEL_MTIME = 2'd3
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] hart;
    logic       hi;
  } reg_sel_t;

  // Unaligned offsets and hart slots beyond num_hart decode as unmapped.
  function automatic reg_sel_t decode_offset(input logic [15:0] off,
                                             input int unsigned num_hart);
    reg_sel_t    sel;
    logic [15:0] msip_rel;
    logic [15:0] cmp_rel;
    sel      = '{kind: SEL_NONE, hart: 3'd0, hi: 1'b0};
    msip_rel = off - MSIP_OFF;
    cmp_rel  = off - MTIMECMP_OFF;
    if (off[1:0] != 2'b00) begin
      sel.kind = SEL_NONE;
    end else if (msip_rel[15:5] == 11'd0 && 32'(msip_rel[4:2]) < num_hart) begin
      sel.kind = SEL_MSIP;
      sel.hart = msip_rel[4:2];
    end else if (cmp_rel[15:6] == 10'd0 && 32'(cmp_rel[5:3]) < num_hart) begin
      sel.kind = SEL_CMP;
      sel.hart = cmp_rel[5:3];
      sel.hi   = cmp_rel[2];
    end else if (off == MTIME_LO_OFF) begin
      sel.kind = SEL_MTIME;
      sel.hi   = 1'b0;
    end else if (off == MTIME_HI_OFF) begin
      sel.kind = SEL_MTIME;
      sel.hi   = 1'b1;
    end else begin
      sel.kind = SEL_NONE;
    end
    return sel;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_24100006_clint_hart_ctx.sv
// One hart's interrupt context: mtimecmp and msip registers with byte-masked
// writes, plus the registered timer-pending compare against the shared mtime.
module ysyx_24100006_clint_hart_ctx
  import ysyx_24100006_clint_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_msip,
  input  logic        we_cmp_lo,
  input  logic        we_cmp_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        msip,
  output logic        mtip
);

  // Context registers; mtip trails the register state by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      if (we_cmp_lo) begin
        mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], wdata, wstrb);
      end
      if (we_cmp_hi) begin
        mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], wdata, wstrb);
      end
      if (we_msip && wstrb[0]) begin
        msip <= wdata[0];
      end
      mtip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/ysyx_24100006_clint_mh.sv
// Multi-hart CLINT top: prescaled 64-bit mtime, per-hart contexts and an
// AXI-Lite slave with independent read and write channels.
module ysyx_24100006_clint_mh
  import ysyx_24100006_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_HART  = 1,
  parameter int          PRESCALE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         axi_araddr,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [31:0]         axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  input  logic [31:0]         axi_awaddr,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [31:0]         axi_wdata,
  input  logic [3:0]          axi_wstrb,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  output logic [NUM_HART-1:0] mtip,
  output logic [NUM_HART-1:0] msip
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0]    presc_r;
  logic [63:0]         mtime_r;
  logic [31:0]         hi_shadow_r;
  rd_state_e           rd_state_r;
  wr_state_e           wr_state_r;
  reg_sel_t            rd_sel_s;
  reg_sel_t            wr_sel_s;
  logic                tick_s;
  logic                wr_fire_s;
  logic                mtime_we_s;
  logic [31:0]         rd_data_s;
  logic [1:0]          rd_resp_s;
  logic [63:0]         cmp_s [MAX_HART];
  logic [MAX_HART-1:0] msip_all_s;
  logic [MAX_HART-1:0] mtip_all_s;
  logic                unused_addr_bits_s;

  // The crossbar owns the upper address bits and the base match.
  assign unused_addr_bits_s = ^{axi_araddr[31:16], axi_awaddr[31:16], BASE_ADDR};

  assign rd_sel_s    = decode_offset(axi_araddr[15:0], NUM_HART);
  assign wr_sel_s    = decode_offset(axi_awaddr[15:0], NUM_HART);
  assign tick_s      = (presc_r == CNT_W'(PRESCALE - 1));
  assign wr_fire_s   = reset && (wr_state_r == W_IDLE) && axi_awvalid && axi_wvalid;
  assign mtime_we_s  = wr_fire_s && (wr_sel_s.kind == SEL_MTIME);
  assign axi_arready = (rd_state_r == R_IDLE);
  assign axi_awready = wr_fire_s;
  assign axi_wready  = wr_fire_s;
  assign mtip        = mtip_all_s[NUM_HART-1:0];
  assign msip        = msip_all_s[NUM_HART-1:0];

  // Prescaler and mtime; a bus write to mtime overrides that cycle's tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r <= {CNT_W{1'b0}};
      mtime_r <= 64'd0;
    end else begin
      presc_r <= tick_s ? {CNT_W{1'b0}} : presc_r + CNT_W'(1);
      if (mtime_we_s) begin
        if (wr_sel_s.hi) begin
          mtime_r[63:32] <= apply_wstrb(mtime_r[63:32], axi_wdata, axi_wstrb);
        end else begin
          mtime_r[31:0] <= apply_wstrb(mtime_r[31:0], axi_wdata, axi_wstrb);
        end
      end else if (tick_s) begin
        mtime_r <= mtime_r + 64'd1;
      end
    end
  end

  for (genvar h = 0; h < MAX_HART; h++) begin : g_hart
    if (h < NUM_HART) begin : g_ctx
      ysyx_24100006_clint_hart_ctx u_ctx (
        .clk       (clk),
        .reset     (reset),
        .we_msip   (wr_fire_s && wr_sel_s.kind == SEL_MSIP && wr_sel_s.hart == 3'(h)),
        .we_cmp_lo (wr_fire_s && wr_sel_s.kind == SEL_CMP && wr_sel_s.hart == 3'(h) && !wr_sel_s.hi),
        .we_cmp_hi (wr_fire_s && wr_sel_s.kind == SEL_CMP && wr_sel_s.hart == 3'(h) && wr_sel_s.hi),
        .wdata     (axi_wdata),
        .wstrb     (axi_wstrb),
        .mtime     (mtime_r),
        .mtimecmp  (cmp_s[h]),
        .msip      (msip_all_s[h]),
        .mtip      (mtip_all_s[h])
      );
    end else begin : g_tie
      assign cmp_s[h]      = 64'hFFFF_FFFF_FFFF_FFFF;
      assign msip_all_s[h] = 1'b0;
      assign mtip_all_s[h] = 1'b0;
    end
  end

  // Read mux over pre-edge register state, so same-edge writes are not seen.
  always_comb begin
    rd_data_s = 32'd0;
    rd_resp_s = RESP_OKAY;
    case (rd_sel_s.kind)
      SEL_MSIP:  rd_data_s = {31'd0, msip_all_s[rd_sel_s.hart]};
      SEL_CMP:   rd_data_s = rd_sel_s.hi ? cmp_s[rd_sel_s.hart][63:32]
                                         : cmp_s[rd_sel_s.hart][31:0];
      SEL_MTIME: rd_data_s = rd_sel_s.hi ? hi_shadow_r : mtime_r[31:0];
      default:   rd_resp_s = RESP_SLVERR;
    endcase
  end

  // Read channel; a low-word mtime read snapshots the high word for later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state_r  <= R_IDLE;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= 32'd0;
      axi_rresp   <= RESP_OKAY;
      hi_shadow_r <= 32'd0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (axi_arvalid) begin
            axi_rdata  <= rd_data_s;
            axi_rresp  <= rd_resp_s;
            axi_rvalid <= 1'b1;
            rd_state_r <= R_RESP;
            if (rd_sel_s.kind == SEL_MTIME && !rd_sel_s.hi) begin
              hi_shadow_r <= mtime_r[63:32];
            end
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            rd_state_r <= R_IDLE;
          end
        end
        default: begin
          axi_rvalid <= 1'b0;
          rd_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel; the register update itself happens in the owning block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_state_r <= W_IDLE;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (wr_fire_s) begin
            axi_bresp  <= (wr_sel_s.kind == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            axi_bvalid <= 1'b1;
            wr_state_r <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            wr_state_r <= W_IDLE;
          end
        end
        default: begin
          axi_bvalid <= 1'b0;
          wr_state_r <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_clint_mh.sv
// Directed-plus-random bench for the CLINT with a time-based reference model:
// mtime is derived from a base value and the clock-edge count since it was set.
module tb_ysyx_24100006_clint_mh;

  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   araddr = 32'd0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [31:0]   awaddr = 32'd0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = 32'd0;
  logic [3:0]    wstrb = 4'd0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [NH-1:0] mtip;
  logic [NH-1:0] msip;

  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [63:0]     m_base;
  longint unsigned m_cyc;
  logic [63:0]     cmp_m [NH];
  logic            msip_m [NH];
  logic [31:0]     sh_m;

  ysyx_24100006_clint_mh #(
    .BASE_ADDR (32'h0200_0000),
    .NUM_HART  (NH),
    .PRESCALE  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .axi_araddr  (araddr),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_rdata   (rdata),
    .axi_rresp   (rresp),
    .axi_rvalid  (rvalid),
    .axi_rready  (rready),
    .axi_awaddr  (awaddr),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wstrb   (wstrb),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_bresp   (bresp),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .mtip        (mtip),
    .msip        (msip)
  );

  // mtime value held after clock edge c (one increment per edge).
  function automatic logic [63:0] mval(input longint unsigned c);
    return m_base + 64'(c - m_cyc);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_base = 64'd0;
    m_cyc  = cyc;
    sh_m   = 32'd0;
    for (int h = 0; h < NH; h++) begin
      cmp_m[h]  = 64'hFFFF_FFFF_FFFF_FFFF;
      msip_m[h] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read accepted at edge e sees the state held before e.
  task automatic model_read(input logic [31:0] a, input longint unsigned e,
                            output logic [31:0] d, output logic [1:0] r);
    int          o;
    int          h;
    logic [63:0] v;
    o = int'(a[15:0]);
    d = 32'd0;
    r = 2'b00;
    if (o % 4 != 0) r = 2'b10;
    else if (o < 4 * NH) d = {31'd0, msip_m[o / 4]};
    else if (o >= 32'h4000 && o < 32'h4000 + 8 * NH) begin
      h = (o - 32'h4000) / 8;
      d = a[2] ? cmp_m[h][63:32] : cmp_m[h][31:0];
    end else if (o == 32'hBFF8) begin
      v    = mval(e - 1);
      d    = v[31:0];
      sh_m = v[63:32];
    end else if (o == 32'hBFFC) d = sh_m;
    else r = 2'b10;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input longint unsigned e, output logic [1:0] r);
    int          o;
    int          h;
    logic [63:0] v;
    o = int'(a[15:0]);
    r = 2'b00;
    if (o % 4 != 0) r = 2'b10;
    else if (o < 4 * NH) begin
      if (s[0]) msip_m[o / 4] = d[0];
    end else if (o >= 32'h4000 && o < 32'h4000 + 8 * NH) begin
      h = (o - 32'h4000) / 8;
      if (a[2]) cmp_m[h][63:32] = merge(cmp_m[h][63:32], d, s);
      else      cmp_m[h][31:0]  = merge(cmp_m[h][31:0], d, s);
    end else if (o == 32'hBFF8 || o == 32'hBFFC) begin
      v = mval(e - 1);
      if (a[2]) v[63:32] = merge(v[63:32], d, s);
      else      v[31:0]  = merge(v[31:0], d, s);
      m_base = v;
      m_cyc  = e;
    end else r = 2'b10;
  endtask

  task automatic do_read(input logic [31:0] a, input string tag, output logic [31:0] got);
    logic [31:0]     ed;
    logic [1:0]      er;
    longint unsigned e;
    int              n;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_arready"}, arready, 1'b1);
    @(posedge clk); #1;
    e = cyc;
    arvalid = 1'b0;
    model_read(a, e, ed, er);
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, rresp, er);
    got = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk({tag, "_rvalid_drop"}, rvalid, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag, output logic [NH-1:0] mtip_acc);
    logic [1:0]      er;
    longint unsigned e;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    #1;
    chk({tag, "_awready"}, {awready, wready}, 2'b11);
    @(posedge clk); #1;
    e = cyc;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    mtip_acc = mtip;
    model_write(a, d, s, e, er);
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bresp"}, bresp, er);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, bvalid, 1'b0);
    chk({tag, "_msip"}, msip, {msip_m[1], msip_m[0]});
  endtask

  initial begin
    logic [31:0]     got;
    logic [31:0]     hold;
    logic [31:0]     ed;
    logic [1:0]      er;
    logic [1:0]      wr;
    logic [NH-1:0]   ma;
    logic [63:0]     t;
    longint unsigned e;
    longint unsigned pred;
    int              n;
    logic [31:0]     rd_addrs [8];
    logic [31:0]     wr_addrs [7];
    rd_addrs = '{32'h0, 32'h4, 32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'hBFF8, 32'hBFFC};
    wr_addrs = '{32'h0, 32'h4, 32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'hBFF8};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("rst_arready", arready, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_awready", {awready, wready}, 2'b00);
    chk("rst_irq", {mtip, msip}, 4'd0);
    reset = 1'b1;

    repeat (10) @(posedge clk);
    #1;
    do_read(32'h0200_BFF8, "mtime_lo_10", got);
    do_read(32'h0200_BFFC, "mtime_hi_0", got);
    do_read(32'h0200_4000, "cmp0_lo_rst", got);
    do_read(32'h0200_400C, "cmp1_hi_rst", got);

    // Atomic mtime read across a low-word wrap
    do_write(32'h0200_BFF8, 32'hFFFF_FFF0, 4'hF, "wr_mtime_lo", ma);
    do_write(32'h0200_BFFC, 32'h0000_0000, 4'hF, "wr_mtime_hi", ma);
    do_read(32'h0200_BFF8, "wrap_lo_pre", got);
    repeat (30) @(posedge clk);
    #1;
    do_read(32'h0200_BFFC, "wrap_hi_shadow", got);
    chk("wrap_shadow_old", got, 32'd0);
    do_read(32'h0200_BFF8, "wrap_lo_post", got);
    do_read(32'h0200_BFFC, "wrap_hi_post", got);
    chk("wrap_hi_carried", got, 32'd1);

    // Random register traffic against the model
    for (int i = 0; i < 12; i++) begin
      do_write(wr_addrs[$urandom_range(6, 0)], $urandom, 4'($urandom_range(15, 0)), "rnd_wr", ma);
      do_read(rd_addrs[$urandom_range(7, 0)], "rnd_rd", got);
    end
    for (int h = 0; h < NH; h++) begin
      do_write(32'h0200_4000 + 32'(8 * h), 32'hFFFF_FFFF, 4'hF, "restore_lo", ma);
      do_write(32'h0200_4004 + 32'(8 * h), 32'hFFFF_FFFF, 4'hF, "restore_hi", ma);
    end
    @(posedge clk); #1;
    chk("mtip_idle", mtip, 2'b00);

    // Timer interrupt on hart 1 only
    t = mval(cyc) + 64'd40;
    do_write(32'h0200_4008, t[31:0], 4'hF, "cmp1_lo", ma);
    do_write(32'h0200_400C, t[63:32], 4'hF, "cmp1_hi", ma);
    pred = m_cyc + 1 + longint'(t - m_base);
    n = 0;
    while (mtip[1] !== 1'b1 && n < 200) begin
      chk("mtip0_quiet", mtip[0], 1'b0);
      @(posedge clk); #1; n++;
    end
    chk("mtip1_rise_cycle", 64'(cyc), 64'(pred));
    chk("mtip0_low", mtip[0], 1'b0);
    do_write(32'h0200_400C, 32'hFFFF_FFFF, 4'hF, "cmp1_clear", ma);
    chk("mtip1_lag", ma[1], 1'b1);
    chk("mtip1_cleared", mtip[1], 1'b0);

    // Software interrupt with byte strobes
    do_write(32'h0200_0004, 32'h1, 4'b0001, "msip1_set", ma);
    chk("msip1_on", msip, 2'b10);
    do_write(32'h0200_0004, 32'h0, 4'b0000, "msip1_nostrb", ma);
    chk("msip1_kept", msip, 2'b10);
    do_write(32'h0200_0000, 32'hFFFF_FFFF, 4'hF, "msip0_all", ma);
    do_read(32'h0200_0000, "msip0_rd", got);
    chk("msip0_only_bit0", got, 32'd1);

    // Unmapped offsets
    do_read(32'h0200_1000, "unmap_rd", got);
    do_read(32'h0200_0008, "unmap_msip2", got);
    do_write(32'h0200_8000, 32'h1234_5678, 4'hF, "unmap_wr", ma);
    do_write(32'h0200_4010, 32'h0, 4'hF, "unmap_cmp2", ma);
    do_read(32'h0200_4004, "cmp0_hi_intact", got);

    // Same-edge read and write of one register
    araddr  = 32'h0200_4000;
    arvalid = 1'b1;
    awaddr  = 32'h0200_4000;
    wdata   = $urandom;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    #1;
    chk("coll_ready", {arready, awready}, 2'b11);
    @(posedge clk); #1;
    e = cyc;
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    model_read(32'h0200_4000, e, ed, er);
    model_write(32'h0200_4000, wdata, wstrb, e, wr);
    chk("coll_rdata_old", rdata, ed);
    chk("coll_bresp", bresp, wr);
    rready = 1'b1;
    bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    bready = 1'b0;
    do_read(32'h0200_4000, "coll_new", got);

    // Backpressure hold, then reset mid-response
    araddr  = 32'h0200_4000;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    model_read(32'h0200_4000, cyc, ed, er);
    hold = ed;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", rvalid, 1'b1);
      chk("hold_rdata", rdata, hold);
      chk("hold_arready", arready, 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    chk("abort_rvalid", rvalid, 1'b0);
    chk("abort_arready", arready, 1'b1);
    chk("abort_bvalid", bvalid, 1'b0);
    chk("abort_irq", {mtip, msip}, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    do_read(32'h0200_BFF8, "post_rst_mtime", got);
    do_read(32'h0200_4000, "post_rst_cmp", got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
